// File: rtl/itrx_aib_phy_clk_mux_ctrl.sv
// itrx_aib_phy_clk_mux_ctrl: glitch-free gate/flip/ungate sequencer for the AIB PHY 2:1 clock MUX.
// Optional DFT override of both clock gates when ITRX_AIB_PHY_CMX_DFT_EN is defined.
module itrx_aib_phy_clk_mux_ctrl #(
  parameter int   SETTLE_CYC = 4,
  parameter logic RESET_SEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_vld,
  input  logic req_sel,
`ifdef ITRX_AIB_PHY_CMX_DFT_EN
  input  logic scan_mode,
`endif
  output logic req_rdy,
  output logic msel,
  output logic cken0,
  output logic cken1,
  output logic busy,
  output logic done
);
  localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CW = $clog2(SC + 1);
  localparam logic [CW-1:0] LAST = CW'(SC - 1);
  typedef enum logic [1:0] {IDLE, GATE_OFF, SWITCH, GATE_ON} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      msel    <= RESET_SEL;
      cken0   <= ~RESET_SEL;
      cken1   <= RESET_SEL;
      req_rdy <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
`ifdef ITRX_AIB_PHY_CMX_DFT_EN
      if (scan_mode) begin
        state   <= IDLE;
        cnt     <= '0;
        cken0   <= 1'b1;
        cken1   <= 1'b1;
        req_rdy <= 1'b0;
        busy    <= 1'b0;
      end else
`endif
      case (state)
        IDLE: begin
          // re-deriving the gates here also restores them after a scan override
          cken0   <= ~msel;
          cken1   <= msel;
          req_rdy <= 1'b1;
          busy    <= 1'b0;
          if (req_vld && req_rdy) begin
            if (req_sel == msel) begin
              done <= 1'b1;
            end else begin
              state   <= GATE_OFF;
              cnt     <= '0;
              cken0   <= 1'b0;
              cken1   <= 1'b0;
              req_rdy <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        GATE_OFF: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            msel  <= ~msel;
            state <= SWITCH;
          end
        end
        SWITCH: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            cken0 <= ~msel;
            cken1 <= msel;
            done  <= 1'b1;
            state <= GATE_ON;
          end
        end
        GATE_ON: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
